// File: rtl/tc_sig_pkg.sv
// ---------------------------------------------------------------------------
// tc_sig_pkg
// Shared definitions for the tensorcore result-signature sink:
//   - state_t      : run-control FSM states
//   - MISR_POLY    : feedback polynomial of the 32-bit signature register
//   - MISR_SEED    : value the signature starts from on reset or restart
//   - fp16_is_nan  : true for an fp16 lane holding a NaN (infinities excluded)
// ---------------------------------------------------------------------------
package tc_sig_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_DRAIN,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
   localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

   // An all-ones exponent with a zero mantissa is an infinity, not a NaN.
   function automatic logic fp16_is_nan(input logic [15:0] h);
      return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
   endfunction

endpackage

// File: rtl/tc_misr32.sv
// ---------------------------------------------------------------------------
// tc_misr32
// 32-bit multiple-input signature register. Each enabled cycle shifts the
// signature left, applies the polynomial feedback when the outgoing bit is
// set, and XORs in one 32-bit data word.
// Ports:
//   clk_600m  in   1   core clock
//   rst       in   1   synchronous active-high reset, loads the seed
//   load      in   1   synchronous seed load (run restart)
//   en        in   1   fold data into the signature this cycle
//   data      in   32  word folded in when en is high
//   sig       out  32  current signature
// ---------------------------------------------------------------------------
module tc_misr32
   import tc_sig_pkg::*;
(
   input  logic        clk_600m,
   input  logic        rst,
   input  logic        load,
   input  logic        en,
   input  logic [31:0] data,
   output logic [31:0] sig
);

   // Seed load takes priority over a fold, so a restart discards any word
   // that was still in flight when the run was restarted.
   always_ff @(posedge clk_600m) begin
      if (rst || load) begin
         sig <= MISR_SEED;
      end else if (en) begin
         sig <= {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ data;
      end
   end

endmodule

// File: rtl/tc_result_signature.sv
// ---------------------------------------------------------------------------
// tc_result_signature
// Sink end of the tensorcore stress harness. Accepts result beats, folds each
// 256-bit beat to 32 bits, compacts the folds into a MISR signature, counts
// fp16 NaN lanes and watches for a stalled core.
// Ports:
//   clk_600m   in   1       core clock
//   rst        in   1       synchronous active-high reset
//   start      in   1       one-cycle pulse: clear state and begin a run
//   out_valid  in   1       result strobe (no backpressure)
//   d_out      in   DATA_W  result word, 16 fp16 lanes
//   done       out  1       run finished by count or by timeout
//   pass       out  1       done, no timeout, signature matched golden
//   timeout    out  1       watchdog fired
//   sig        out  32      current signature
//   beat_cnt   out  CNT_W   beats accepted this run
//   nan_cnt    out  CNT_W   NaN lanes seen this run, saturating
//   led        out  8       {sig[3:0], nan_cnt!=0, timeout, pass, done}
// ---------------------------------------------------------------------------
module tc_result_signature
   import tc_sig_pkg::*;
#(
   parameter int          DATA_W     = 256,
   parameter int          N_RESULTS  = 1024,
   parameter int          TIMEOUT    = 4096,
   parameter logic [31:0] GOLDEN_SIG = 32'hC7B0424D,
   parameter int          CNT_W      = 16
) (
   input  logic              clk_600m,
   input  logic              rst,
   input  logic              start,
   input  logic              out_valid,
   input  logic [DATA_W-1:0] d_out,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [31:0]       sig,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  nan_cnt,
   output logic [7:0]        led
);

   localparam int SLICES = DATA_W / 32;
   localparam int LANES  = DATA_W / 16;
   localparam int POP_W  = $clog2(LANES + 1);
   localparam int WD_W   = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N_RESULTS);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

   state_t            state;
   state_t            state_next;
   logic              accept;
   logic              wd_expire;
   logic [31:0]       fold;
   logic [31:0]       fold_r;
   logic              fold_v;
   logic [POP_W-1:0]  nan_pop;
   logic [CNT_W:0]    nan_sum;
   logic [CNT_W-1:0]  nan_next;
   logic [WD_W-1:0]   wd;

   // Beats only count while collecting and the run is not yet full; the
   // watchdog expires on the cycle it would reach TIMEOUT without a beat.
   assign accept    = out_valid && (state == S_COLLECT) && (beat_cnt < N_LAST);
   assign wd_expire = (state == S_COLLECT) && !accept && (wd == WD_LIMIT);

   // Fold the wide beat down to one 32-bit word and count NaN lanes in it.
   always_comb begin
      fold    = 32'h0;
      nan_pop = '0;
      for (int i = 0; i < SLICES; i++) begin
         fold = fold ^ d_out[i*32 +: 32];
      end
      for (int i = 0; i < LANES; i++) begin
         nan_pop = nan_pop + POP_W'(fp16_is_nan(d_out[i*16 +: 16]));
      end
   end

   // Saturating NaN accumulation: the extra top bit of the sum flags overflow.
   assign nan_sum  = {1'b0, nan_cnt} + (CNT_W + 1)'(nan_pop);
   assign nan_next = nan_sum[CNT_W] ? '1 : nan_sum[CNT_W-1:0];

   // State register.
   always_ff @(posedge clk_600m) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. The run leaves COLLECT on the edge that accepts the
   // last beat, giving the final fold one DRAIN cycle to land in the MISR
   // before CHECK compares it. start from any state restarts the run.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_COLLECT;
         S_COLLECT: begin
            if (accept && (beat_cnt == N_LAST - CNT_W'(1))) begin
               state_next = S_DRAIN;
            end else if (wd_expire) begin
               state_next = S_DONE;
            end
         end
         S_DRAIN:   state_next = S_CHECK;
         S_CHECK:   state_next = S_DONE;
         S_DONE:    if (start) state_next = S_COLLECT;
         default:   state_next = S_IDLE;
      endcase
      if (start) begin
         state_next = S_COLLECT;
      end
   end

   // Datapath and status registers. start wipes every run register; an
   // accepted beat latches its fold and bumps the counters; the watchdog
   // counts idle COLLECT cycles; pass is resolved once, in CHECK.
   always_ff @(posedge clk_600m) begin
      if (rst || start) begin
         fold_r   <= 32'h0;
         fold_v   <= 1'b0;
         beat_cnt <= '0;
         nan_cnt  <= '0;
         wd       <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         fold_v <= accept;
         if (accept) begin
            fold_r   <= fold;
            beat_cnt <= beat_cnt + CNT_W'(1);
            nan_cnt  <= nan_next;
            wd       <= '0;
         end else if (state == S_COLLECT) begin
            wd <= wd + WD_W'(1);
            if (wd_expire) begin
               done    <= 1'b1;
               timeout <= 1'b1;
            end
         end
         if (state == S_CHECK) begin
            done <= 1'b1;
            pass <= (sig == GOLDEN_SIG);
         end
      end
   end

   tc_misr32 u_misr (
      .clk_600m (clk_600m),
      .rst      (rst),
      .load     (start),
      .en       (fold_v),
      .data     (fold_r),
      .sig      (sig)
   );

   assign led = {sig[3:0], (nan_cnt != '0), timeout, pass, done};

endmodule

// File: tb/tb_tc_result_signature.sv
// ---------------------------------------------------------------------------
// tb_tc_result_signature
// Self-checking bench for tc_result_signature. One instance runs short
// 4-beat runs with a 16-cycle watchdog; a second, longer instance exercises
// NaN-counter saturation. Expected values come from a queue-based reference
// model of the signature and NaN rules.
// ---------------------------------------------------------------------------
module tb_tc_result_signature;

   localparam logic [31:0] GOLDEN = 32'hC7B0424D;

   logic         clk_600m;
   logic         rst;
   logic         start;
   logic         start_b;
   logic         out_valid;
   logic [255:0] d_out;

   logic         done, pass, timeout;
   logic [31:0]  sig;
   logic [15:0]  beat_cnt, nan_cnt;
   logic [7:0]   led;

   logic         done_b, pass_b, timeout_b;
   logic [31:0]  sig_b;
   logic [15:0]  beat_cnt_b, nan_cnt_b;
   logic [7:0]   led_b;

   int compared;
   int mismatched;

   logic [255:0] runBeats[$];

   tc_result_signature #(
      .DATA_W(256), .N_RESULTS(4), .TIMEOUT(16), .GOLDEN_SIG(GOLDEN), .CNT_W(16)
   ) dut (
      .clk_600m (clk_600m),
      .rst      (rst),
      .start    (start),
      .out_valid(out_valid),
      .d_out    (d_out),
      .done     (done),
      .pass     (pass),
      .timeout  (timeout),
      .sig      (sig),
      .beat_cnt (beat_cnt),
      .nan_cnt  (nan_cnt),
      .led      (led)
   );

   tc_result_signature #(
      .DATA_W(256), .N_RESULTS(5000), .TIMEOUT(16), .GOLDEN_SIG(GOLDEN), .CNT_W(16)
   ) dut_b (
      .clk_600m (clk_600m),
      .rst      (rst),
      .start    (start_b),
      .out_valid(out_valid),
      .d_out    (d_out),
      .done     (done_b),
      .pass     (pass_b),
      .timeout  (timeout_b),
      .sig      (sig_b),
      .beat_cnt (beat_cnt_b),
      .nan_cnt  (nan_cnt_b),
      .led      (led_b)
   );

   // Free-running core clock.
   initial clk_600m = 1'b0;
   always #5 clk_600m = ~clk_600m;

   // Signature of a whole run, from the seed through every beat in order,
   // done as a 33-bit polynomial reduction per step.
   function automatic logic [31:0] modelSig();
      longint unsigned s;
      logic [31:0]     f;
      s = 64'hFFFFFFFF;
      foreach (runBeats[k]) begin
         f = 32'h0;
         for (int j = 0; j < 8; j++) f = f ^ runBeats[k][j*32 +: 32];
         s = s << 1;
         if (s >= 64'h100000000) s = s ^ 64'h104C11DB7;
         s = (s ^ {32'h0, f}) & 64'hFFFFFFFF;
      end
      return s[31:0];
   endfunction

   function automatic int nanLanes(input logic [255:0] b);
      int n;
      int h;
      n = 0;
      for (int l = 0; l < 16; l++) begin
         h = int'(b[l*16 +: 16]);
         if ((((h >> 10) & 31) == 31) && ((h & 1023) != 0)) n++;
      end
      return n;
   endfunction

   function automatic logic [15:0] modelNan();
      int total;
      total = 0;
      foreach (runBeats[k]) total += nanLanes(runBeats[k]);
      return (total > 65535) ? 16'hFFFF : 16'(total);
   endfunction

   // Random beat with a good share of NaN and infinity lanes.
   function automatic logic [255:0] randBeat();
      logic [255:0] b;
      for (int l = 0; l < 16; l++) begin
         case ($urandom_range(0, 4))
            0:       b[l*16 +: 16] = {1'($urandom_range(0, 1)), 5'h1F, 10'($urandom_range(1, 1023))};
            1:       b[l*16 +: 16] = {1'($urandom_range(0, 1)), 15'h7C00};
            default: b[l*16 +: 16] = 16'($urandom);
         endcase
      end
      return b;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of the result interface and step past the active edge.
   task automatic applyStimulus(input logic valid, input logic [255:0] data);
      out_valid = valid;
      d_out     = data;
      @(posedge clk_600m);
      #1;
      out_valid = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      applyStimulus(1'b0, randBeat());
      start = 1'b0;
   endtask

   // Start a run, feed runBeats with gap idle cycles between beats, then
   // check completion timing and every status output against the model.
   task automatic doRun(input int gap, input string name);
      int          lat;
      logic [31:0] expSig;
      logic [15:0] expNan;
      logic        expPass;
      pulseStart();
      for (int i = 0; i < runBeats.size(); i++) begin
         applyStimulus(1'b1, runBeats[i]);
         if (i < runBeats.size() - 1) begin
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, randBeat());
         end
      end
      lat = 0;
      while (!done && lat < 20) begin
         applyStimulus(1'b0, randBeat());
         lat++;
      end
      expSig  = modelSig();
      expNan  = modelNan();
      expPass = (expSig == GOLDEN);
      checkOutput({name, ".lat"},     32'(lat), 32'd2);
      checkOutput({name, ".sig"},     sig, expSig);
      checkOutput({name, ".done"},    32'(done), 32'd1);
      checkOutput({name, ".timeout"}, 32'(timeout), 32'd0);
      checkOutput({name, ".pass"},    32'(pass), 32'(expPass));
      checkOutput({name, ".beats"},   32'(beat_cnt), 32'd4);
      checkOutput({name, ".nan"},     32'(nan_cnt), 32'(expNan));
      checkOutput({name, ".led"},     32'(led), 32'({expSig[3:0], expNan != 16'h0, 1'b0, expPass, 1'b1}));
   endtask

   task automatic zeroBeats();
      runBeats.delete();
      repeat (4) runBeats.push_back(256'h0);
   endtask

   initial begin
      logic [255:0] b;
      logic [255:0] allNan;
      int           lat;
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      start      = 1'b0;
      start_b    = 1'b0;
      out_valid  = 1'b0;
      d_out      = '0;
      $display("[TB] reset");
      applyStimulus(1'b0, 256'h0);
      applyStimulus(1'b1, randBeat());
      checkOutput("rst.sig",   sig, 32'hFFFFFFFF);
      checkOutput("rst.flags", 32'({done, pass, timeout}), 32'd0);
      checkOutput("rst.beats", 32'(beat_cnt), 32'd0);
      checkOutput("rst.nan",   32'(nan_cnt), 32'd0);
      checkOutput("rst.led",   32'(led), 32'hF0);
      rst = 1'b0;

      // Beats in IDLE are dropped.
      applyStimulus(1'b1, randBeat());
      applyStimulus(1'b1, randBeat());
      checkOutput("idle.beats", 32'(beat_cnt), 32'd0);

      $display("[TB] zero beats back-to-back");
      zeroBeats();
      doRun(0, "zero");

      // Beats while DONE leave everything unchanged.
      applyStimulus(1'b1, randBeat());
      applyStimulus(1'b1, randBeat());
      checkOutput("doneHold.beats", 32'(beat_cnt), 32'd4);
      checkOutput("doneHold.sig",   sig, GOLDEN);
      checkOutput("doneHold.pass",  32'(pass), 32'd1);

      $display("[TB] corrupted beat 3");
      zeroBeats();
      runBeats[2] = 256'h1;
      doRun(0, "corrupt");

      $display("[TB] NaN lane mix");
      zeroBeats();
      runBeats[0] = {208'h0, 16'hFC01, 16'h7C00, 16'h7E00};
      doRun(0, "nanMix");
      checkOutput("nanMix.two", 32'(nan_cnt), 32'd2);

      $display("[TB] gapped zero beats");
      zeroBeats();
      doRun(3, "gap3");

      $display("[TB] random runs");
      for (int r = 0; r < 8; r++) begin
         runBeats.delete();
         repeat (4) runBeats.push_back(randBeat());
         doRun(int'($urandom_range(0, 5)), $sformatf("rand%0d", r));
      end

      $display("[TB] watchdog");
      pulseStart();
      repeat (15) applyStimulus(1'b0, randBeat());
      checkOutput("wd.early", 32'(done), 32'd0);
      applyStimulus(1'b0, randBeat());
      checkOutput("wd.done",    32'(done), 32'd1);
      checkOutput("wd.timeout", 32'(timeout), 32'd1);
      checkOutput("wd.pass",    32'(pass), 32'd0);
      checkOutput("wd.sig",     sig, 32'hFFFFFFFF);
      checkOutput("wd.led",     32'(led), 32'hF5);

      $display("[TB] restart mid-collect");
      pulseStart();
      applyStimulus(1'b1, randBeat());
      applyStimulus(1'b1, randBeat());
      zeroBeats();
      doRun(0, "restart");

      $display("[TB] reset mid-run");
      allNan = {16{16'h7E01}};
      pulseStart();
      applyStimulus(1'b1, allNan);
      applyStimulus(1'b1, allNan);
      checkOutput("midRst.preNan", 32'(nan_cnt), 32'd32);
      rst = 1'b1;
      applyStimulus(1'b0, randBeat());
      rst = 1'b0;
      checkOutput("midRst.sig",   sig, 32'hFFFFFFFF);
      checkOutput("midRst.beats", 32'(beat_cnt), 32'd0);
      checkOutput("midRst.nan",   32'(nan_cnt), 32'd0);
      checkOutput("midRst.led",   32'(led), 32'hF0);
      applyStimulus(1'b1, randBeat());
      checkOutput("midRst.idle", 32'(beat_cnt), 32'd0);

      $display("[TB] reset with start");
      pulseStart();
      applyStimulus(1'b1, randBeat());
      rst   = 1'b1;
      start = 1'b1;
      applyStimulus(1'b0, randBeat());
      rst   = 1'b0;
      start = 1'b0;
      applyStimulus(1'b1, randBeat());
      checkOutput("rstStart.beats", 32'(beat_cnt), 32'd0);
      checkOutput("rstStart.sig",   sig, 32'hFFFFFFFF);

      $display("[TB] NaN saturation");
      runBeats.delete();
      start_b = 1'b1;
      applyStimulus(1'b0, 256'h0);
      start_b = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         b = allNan;
         b[255:240] = 16'($urandom_range(0, 1) ? 16'h7C00 : 16'hFE00);
         runBeats.push_back(b);
         applyStimulus(1'b1, b);
         if (i == 99) checkOutput("sat.partial", 32'(nan_cnt_b), 32'(modelNan()));
      end
      lat = 0;
      while (!done_b && lat < 20) begin
         applyStimulus(1'b0, 256'h0);
         lat++;
      end
      checkOutput("sat.lat",   32'(lat), 32'd2);
      checkOutput("sat.nan",   32'(nan_cnt_b), 32'(modelNan()));
      checkOutput("sat.beats", 32'(beat_cnt_b), 32'd5000);
      checkOutput("sat.sig",   sig_b, modelSig());
      checkOutput("sat.led",   32'(led_b), 32'({sig_b[3:0], 1'b1, timeout_b, pass_b, 1'b1}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
